seq_controller: RTL and testbench



---
 rtl/seq_controller_pkg.sv | 33 +++
 rtl/seq_controller_if.sv | 28 ++
 rtl/seq_controller_phase_counter.sv | 28 ++
 rtl/seq_controller.sv | 115 +++++++++++
 tb/tb_seq_controller.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_controller_pkg.sv
// Shared constants for the instruction sequencer: opcode encodings,
// phase encoding and widths, plus the ALU-opcode classifier.
package seq_ctrl_pkg;

  localparam int OPCODE_W = 3;
  localparam int PHASE_W  = 3;

  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes that read a memory operand and load the accumulator.
  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Opcode/flag inputs and datapath strobes of the sequencer.
// master = sequencer side, slave = datapath side.
interface seq_controller_if;
  import seq_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                sel;
  logic                rd;
  logic                wr;
  logic                ld_ir;
  logic                inc_pc;
  logic                ld_pc;
  logic                ld_ac;
  logic                data_e;
  logic                halt;

  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt
  );

endinterface

// File: rtl/seq_controller_phase_counter.sv
// 3-bit wrapping phase counter; hold freezes the current phase.
module phase_counter
  import seq_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  output phase_t phase
);

  phase_t              phase_next;
  logic [PHASE_W-1:0]  phase_inc;

  assign phase_inc = phase + 3'd1;

  // Next phase: advance with natural 7->0 wrap unless held.
  always_comb begin
    phase_next = phase;
    if (!hold) phase_next = phase_t'(phase_inc);
  end

  // Phase register with synchronous reset to INST_ADDR.
  always_ff @(posedge clk) begin
    if (rst) phase <= INST_ADDR;
    else     phase <= phase_next;
  end

endmodule

// File: rtl/seq_controller.sv
// Eight-phase instruction sequencer generating all datapath strobes.
// Optional build macro: SEQ_CTRL_SINGLE_STEP_EN adds a 'step' input that
// gates each instruction start in INST_ADDR.
//
// phase      | meaning
// INST_ADDR  | PC on address bus (waits for step when single-stepping)
// INST_FETCH | read instruction
// INST_LOAD  | read instruction, load IR
// IDLE       | hold IR load, opcode now valid
// OP_ADDR    | operand address, increment PC; HLT freezes here
// OP_FETCH   | read operand for ALU ops
// ALU_OP     | ALU op / SKZ skip / JMP load / STO drive data
// STORE      | accumulator load / STO write / JMP load
module seq_controller
  import seq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  seq_controller_if.master bus
`ifdef SEQ_CTRL_SINGLE_STEP_EN
  ,
  input  logic step
`endif
);

  phase_t phase;
  logic   halted_q;
  logic   halt_now;
  logic   freeze;
  logic   hold;
  logic   aluop;

  logic sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;

  assign aluop    = is_aluop(bus.opcode);
  // Once latched, the halt no longer depends on the opcode input.
  assign halt_now = halted_q || (bus.opcode == HLT);
  assign freeze   = (phase == OP_ADDR) && halt_now;

`ifdef SEQ_CTRL_SINGLE_STEP_EN
  assign hold = freeze || ((phase == INST_ADDR) && !step);
`else
  assign hold = freeze;
`endif

  phase_counter u_phase (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .phase (phase)
  );

  // Halt latch: set on an HLT in OP_ADDR, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                                         halted_q <= 1'b0;
    else if ((phase == OP_ADDR) && (bus.opcode == HLT)) halted_q <= 1'b1;
  end

  // Strobe decode from phase and opcode.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    unique case (phase)
      INST_ADDR:  ;
      INST_FETCH: rd = 1'b1;
      INST_LOAD, IDLE: begin
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        sel    = 1'b1;
        halt   = halt_now;
        inc_pc = !halt_now;
      end
      OP_FETCH: begin
        sel = 1'b1;
        rd  = aluop;
      end
      ALU_OP: begin
        sel    = 1'b1;
        rd     = aluop;
        inc_pc = (bus.opcode == SKZ) && bus.zero;
        ld_pc  = (bus.opcode == JMP);
        data_e = (bus.opcode == STO);
      end
      STORE: begin
        sel    = 1'b1;
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = (bus.opcode == JMP);
        wr     = (bus.opcode == STO);
        data_e = (bus.opcode == STO);
      end
      default: ;
    endcase
  end

  assign bus.sel    = sel;
  assign bus.rd     = rd;
  assign bus.wr     = wr;
  assign bus.ld_ir  = ld_ir;
  assign bus.inc_pc = inc_pc;
  assign bus.ld_pc  = ld_pc;
  assign bus.ld_ac  = ld_ac;
  assign bus.data_e = data_e;
  assign bus.halt   = halt;

endmodule

// File: tb/tb_seq_controller.sv
// Directed testbench for seq_controller.
// Output vector order: {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}
module tb_seq_controller;
  import seq_ctrl_pkg::*;

  logic clk;
  logic rst;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
  logic step;
`endif

  seq_controller_if bus ();

  seq_controller dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    ,
    .step (step)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] obs;
  logic [2:0] ph;
  assign obs = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.inc_pc,
                bus.ld_pc, bus.ld_ac, bus.data_e, bus.halt};
  assign ph  = dut.u_phase.phase;

  localparam logic [8:0] EXP_LDA [8] = '{
    9'b000000000, 9'b010000000, 9'b010100000, 9'b010100000,
    9'b100010000, 9'b110000000, 9'b110000000, 9'b110000100 };
  localparam logic [8:0] EXP_STO [8] = '{
    9'b000000000, 9'b010000000, 9'b010100000, 9'b010100000,
    9'b100010000, 9'b100000000, 9'b100000010, 9'b101000010 };
  localparam logic [8:0] EXP_SKZ1 [8] = '{
    9'b000000000, 9'b010000000, 9'b010100000, 9'b010100000,
    9'b100010000, 9'b100000000, 9'b100010000, 9'b100000000 };
  localparam logic [8:0] EXP_SKZ0 [8] = '{
    9'b000000000, 9'b010000000, 9'b010100000, 9'b010100000,
    9'b100010000, 9'b100000000, 9'b100000000, 9'b100000000 };
  localparam logic [8:0] EXP_JMP [8] = '{
    9'b000000000, 9'b010000000, 9'b010100000, 9'b010100000,
    9'b100010000, 9'b100000000, 9'b100001000, 9'b100001000 };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.opcode = LDA;
    bus.zero = 1'b0;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    tick();
    tick();
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 9'b0);
    end
    n_checks++;
    if (ph !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_phase: got %0d expected 0", ph);
    end
    rst = 1'b0;
  endtask

  task automatic test_lda();
    bus.opcode = LDA;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs !== EXP_LDA[p] || ph !== 3'(p)) begin
        n_fail++;
        $display("FAIL lda_p%0d: got %b phase %0d expected %b phase %0d", p, obs, ph, EXP_LDA[p], p);
      end
      tick();
    end
  endtask

  task automatic test_sto();
    bus.opcode = STO;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs !== EXP_STO[p] || ph !== 3'(p)) begin
        n_fail++;
        $display("FAIL sto_p%0d: got %b phase %0d expected %b phase %0d", p, obs, ph, EXP_STO[p], p);
      end
      tick();
    end
  endtask

  task automatic test_skz();
    bus.opcode = SKZ;
    bus.zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs !== EXP_SKZ1[p]) begin
        n_fail++;
        $display("FAIL skz_zero1_p%0d: got %b expected %b", p, obs, EXP_SKZ1[p]);
      end
      tick();
    end
    bus.zero = 1'b0;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs !== EXP_SKZ0[p]) begin
        n_fail++;
        $display("FAIL skz_zero0_p%0d: got %b expected %b", p, obs, EXP_SKZ0[p]);
      end
      tick();
    end
  endtask

  task automatic test_jmp();
    bus.opcode = JMP;
    for (int p = 0; p < 8; p++) begin
      n_checks++;
      if (obs !== EXP_JMP[p]) begin
        n_fail++;
        $display("FAIL jmp_p%0d: got %b expected %b", p, obs, EXP_JMP[p]);
      end
      tick();
    end
  endtask

  // Opcode wiggles during phases 0-2 must not disturb fetch strobes;
  // the instruction then executes as XOR (an ALU op, same strobes as LDA).
  task automatic test_fetch_opcode_indep();
    logic [2:0] wiggle [3];
    wiggle[0] = HLT;
    wiggle[1] = STO;
    wiggle[2] = JMP;
    for (int p = 0; p < 8; p++) begin
      if (p < 3) bus.opcode = wiggle[p];
      else       bus.opcode = XOR;
      #1;
      n_checks++;
      if (obs !== EXP_LDA[p]) begin
        n_fail++;
        $display("FAIL fetch_indep_p%0d: got %b expected %b", p, obs, EXP_LDA[p]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    bus.opcode = HLT;
    for (int p = 0; p < 4; p++) tick();
    n_checks++;
    if (ph !== 3'd4 || bus.halt !== 1'b1 || bus.sel !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_entry: got phase %0d halt %b sel %b expected phase 4 halt 1 sel 1", ph, bus.halt, bus.sel);
    end
    for (int c = 0; c < 22; c++) begin
      tick();
      if (c == 10) bus.opcode = LDA;
      #1;
      n_checks++;
      if (ph !== 3'd4 || bus.halt !== 1'b1 || bus.inc_pc !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_frozen_c%0d: got phase %0d halt %b inc_pc %b expected phase 4 halt 1 inc_pc 0", c, ph, bus.halt, bus.inc_pc);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (ph !== 3'd0 || obs !== 9'b0) begin
      n_fail++;
      $display("FAIL halt_exit: got phase %0d out %b expected phase 0 out %b", ph, obs, 9'b0);
    end
    tick();
    n_checks++;
    if (ph !== 3'd1 || obs !== EXP_LDA[1]) begin
      n_fail++;
      $display("FAIL halt_resume: got phase %0d out %b expected phase 1 out %b", ph, obs, EXP_LDA[1]);
    end
    for (int p = 1; p < 8; p++) tick();
  endtask

  task automatic test_reset_mid_store();
    bus.opcode = STO;
    for (int p = 0; p < 7; p++) tick();
    n_checks++;
    if (ph !== 3'd7 || bus.wr !== 1'b1) begin
      n_fail++;
      $display("FAIL store_reached: got phase %0d wr %b expected phase 7 wr 1", ph, bus.wr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (ph !== 3'd0 || bus.wr !== 1'b0 || bus.data_e !== 1'b0 || obs !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_mid_store: got phase %0d out %b expected phase 0 out %b", ph, obs, 9'b0);
    end
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    step = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (ph !== 3'd0 || obs !== 9'b0) begin
        n_fail++;
        $display("FAIL step_hold_c%0d: got phase %0d out %b expected phase 0 out %b", c, ph, obs, 9'b0);
      end
    end
    step = 1'b1;
    tick();
    n_checks++;
    if (ph !== 3'd1) begin
      n_fail++;
      $display("FAIL step_release: got phase %0d expected 1", ph);
    end
    for (int p = 1; p < 8; p++) tick();
`endif
  endtask

  // LDA immediately followed by STO with no gap.
  task automatic test_back_to_back();
    test_lda();
    test_sto();
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sto();
    test_skz();
    test_jmp();
    test_fetch_opcode_indep();
    test_back_to_back();
    test_halt();
    test_reset_mid_store();
    test_lda();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
